// File: rtl/nervous_pulse_transmitter.sv
// nervous_pulse_transmitter
//   Queues 2-bit abnormality codes in a small FIFO and serialises each one
//   as a framed pulse train for the shock detector:
//     start '1', code[1], code[0], parity (code[1]^code[0]), GUARD_BITS x '0'
//   Each accepted code is sent REPEAT times back-to-back. Consecutive frames
//   are contiguous, with no idle bit between them. The idle line level is '0'.
//
// Ports
//   clock       in   rising-edge system clock
//   resetn      in   asynchronous active-low reset (aborts any frame, flushes FIFO)
//   code_valid  in   code_in holds a code to queue
//   code_in     in   [1:0] code: 00 normal, 01 mild, 10 severe, 11 shock
//   code_ready  out  FIFO not full (registered occupancy only)
//   inputdata   out  registered serial line, one bit per clock
//   busy        out  FSM not idle or FIFO non-empty
//   frame_done  out  one-cycle pulse aligned with the last guard bit on the line
module nervous_pulse_transmitter #(
    parameter int GUARD_BITS = 2,   // 1..15
    parameter int REPEAT     = 1,   // 1..7
    parameter int FIFO_DEPTH = 4    // power of two, 2..16
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       code_valid,
    input  logic [1:0] code_in,
    output logic       code_ready,
    output logic       inputdata,
    output logic       busy,
    output logic       frame_done
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [3:0]    GLAST    = 4'(GUARD_BITS - 1);
    localparam logic [2:0]    REP_INIT = 3'(REPEAT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA1, DATA0, PARITY, GUARD} state_t;

    // ---------------------------------------------------------------- FIFO
    logic [1:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] cnt_q;
    logic          push, pop;
    logic          fifo_nempty;
    logic [1:0]    head;

    assign code_ready  = (cnt_q != FULL_CNT);
    assign push        = code_valid && code_ready;
    assign fifo_nempty = (cnt_q != '0);
    assign head        = mem_q[rptr_q];

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wptr_q] <= code_in;
                wptr_q        <= wptr_q + 1'b1;
            end
            if (pop) rptr_q <= rptr_q + 1'b1;
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // ---------------------------------------------------------------- FSM
    state_t     state_q, state_d;
    logic [1:0] code_q, code_d;
    logic [2:0] rep_q, rep_d;
    logic [3:0] gcnt_q, gcnt_d;
    logic       bit_d, fd_d;
    logic       inputdata_q, frame_done_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            code_q       <= '0;
            rep_q        <= '0;
            gcnt_q       <= '0;
            inputdata_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            code_q       <= code_d;
            rep_q        <= rep_d;
            gcnt_q       <= gcnt_d;
            inputdata_q  <= bit_d;
            frame_done_q <= fd_d;
        end
    end

    // bit_d / fd_d describe the current state; they reach the pins one clock
    // later through the output registers, so frame_done lines up with the
    // last guard bit actually on the wire.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        rep_d   = rep_q;
        gcnt_d  = gcnt_q;
        pop     = 1'b0;
        bit_d   = 1'b0;
        fd_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (fifo_nempty) begin
                    pop     = 1'b1;
                    code_d  = head;
                    rep_d   = REP_INIT;
                    state_d = START;
                end
            end
            START: begin
                bit_d   = 1'b1;
                state_d = DATA1;
            end
            DATA1: begin
                bit_d   = code_q[1];
                state_d = DATA0;
            end
            DATA0: begin
                bit_d   = code_q[0];
                state_d = PARITY;
            end
            PARITY: begin
                bit_d   = code_q[1] ^ code_q[0];
                gcnt_d  = '0;
                state_d = GUARD;
            end
            GUARD: begin
                if (gcnt_q == GLAST) begin
                    fd_d   = 1'b1;
                    gcnt_d = '0;
                    if (rep_q != 3'd0) begin
                        // Resend the same code; rep_q never wraps below zero.
                        rep_d   = rep_q - 3'd1;
                        state_d = START;
                    end else if (fifo_nempty) begin
                        pop     = 1'b1;
                        code_d  = head;
                        rep_d   = REP_INIT;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    gcnt_d = gcnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign inputdata  = inputdata_q;
    assign frame_done = frame_done_q;
    assign busy       = (state_q != IDLE) || fifo_nempty;

endmodule
